// File: rtl/pool_window_gen.sv
// pool_window_gen: streaming 3x3 window generator over a raster-order
// int8 feature map, emitting one window per STRIDE step in each direction.
//
// Ports:
//   clk                        rising-edge clock
//   rst                        synchronous active-high reset
//   pix_valid, pix_in[7:0]     incoming pixel, raster order
//   data_out0..data_out8[7:0]  window, row-major, data_out0 top-left
//   valid_out                  one-cycle pulse when a window is presented
//   frame_done                 one-cycle pulse after the last pixel of a
//                              frame (only with POOL_WINDOW_GEN_FRAME_DONE_EN)
//
// Build option: define POOL_WINDOW_GEN_FRAME_DONE_EN to add frame_done.
module pool_window_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int STRIDE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  input  logic [7:0] pix_in,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic [7:0] data_out2,
  output logic [7:0] data_out3,
  output logic [7:0] data_out4,
  output logic [7:0] data_out5,
  output logic [7:0] data_out6,
  output logic [7:0] data_out7,
  output logic [7:0] data_out8,
  output logic       valid_out
`ifdef POOL_WINDOW_GEN_FRAME_DONE_EN
  ,
  output logic       frame_done
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [1:0]    PH_LAST  = 2'(STRIDE - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    col_ph;
  logic [1:0]    row_ph;

  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];
  logic [7:0] rd1;
  logic [7:0] rd2;

  logic [7:0] hist [6];
  logic [7:0] nw   [9];
  logic [7:0] dout [9];

  logic accept;
  logic col_end;
  logic row_end;
  logic hit;

  assign accept  = pix_valid & ~rst;
  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);

  // Phase counters sit at 0 for positions 0..2 and then count mod STRIDE,
  // so phase 0 at position >= 2 means (pos-2) is a multiple of STRIDE.
  assign hit = (col >= COL_TWO) && (row >= ROW_TWO) &&
               (col_ph == 2'd0) && (row_ph == 2'd0);

  // lb1 holds row r-1, lb2 holds row r-2, both indexed by column.
  assign rd1 = lb1[col];
  assign rd2 = lb2[col];

  // Window after this pixel shifts in: two history columns plus the new
  // right-hand column taken from the line buffers and the live pixel.
  always_comb begin
    nw[0] = hist[0];
    nw[1] = hist[1];
    nw[2] = rd2;
    nw[3] = hist[2];
    nw[4] = hist[3];
    nw[5] = rd1;
    nw[6] = hist[4];
    nw[7] = hist[5];
    nw[8] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      col_ph <= '0;
      row_ph <= '0;
    end else if (accept) begin
      if (col_end) begin
        col    <= '0;
        col_ph <= '0;
        if (row_end) begin
          row    <= '0;
          row_ph <= '0;
        end else begin
          row    <= row + 1'b1;
          row_ph <= (row < ROW_TWO || row_ph == PH_LAST) ?
                    2'd0 : row_ph + 2'd1;
        end
      end else begin
        col    <= col + 1'b1;
        col_ph <= (col < COL_TWO || col_ph == PH_LAST) ?
                  2'd0 : col_ph + 2'd1;
      end
    end
  end

  // Line buffers need no reset: a window is only emitted once both rows
  // above it and its two left columns were written in the current frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= pix_in;
      lb2[col] <= rd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      for (int i = 0; i < 6; i++) hist[i] <= '0;
      for (int i = 0; i < 9; i++) dout[i] <= '0;
    end else begin
      valid_out <= accept & hit;
      if (accept) begin
        hist[0] <= nw[1];
        hist[1] <= nw[2];
        hist[2] <= nw[4];
        hist[3] <= nw[5];
        hist[4] <= nw[7];
        hist[5] <= nw[8];
        if (hit) begin
          for (int i = 0; i < 9; i++) dout[i] <= nw[i];
        end
      end
    end
  end

`ifdef POOL_WINDOW_GEN_FRAME_DONE_EN
  always_ff @(posedge clk) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= accept & col_end & row_end;
  end
`endif

  assign data_out0 = dout[0];
  assign data_out1 = dout[1];
  assign data_out2 = dout[2];
  assign data_out3 = dout[3];
  assign data_out4 = dout[4];
  assign data_out5 = dout[5];
  assign data_out6 = dout[6];
  assign data_out7 = dout[7];
  assign data_out8 = dout[8];

endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen: bench for pool_window_gen on a 6x6 map with
// STRIDE=3 and STRIDE=1 instances fed the same pixel stream.
module tb_pool_window_gen;

  typedef logic [0:8][7:0] win_t;

  logic clk = 1'b0;
  logic rst;
  logic pix_valid;
  logic [7:0] pix_in;
  win_t o3, o1;
  logic v3, v1;
`ifdef POOL_WINDOW_GEN_FRAME_DONE_EN
  logic fd3, fd1;
  int nfd3 = 0;
`endif

  int nvec = 0;
  int nfail = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  pool_window_gen #(.IMG_W(6), .IMG_H(6), .STRIDE(3)) dut3 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_in(pix_in),
    .data_out0(o3[0]), .data_out1(o3[1]), .data_out2(o3[2]),
    .data_out3(o3[3]), .data_out4(o3[4]), .data_out5(o3[5]),
    .data_out6(o3[6]), .data_out7(o3[7]), .data_out8(o3[8]),
    .valid_out(v3)
`ifdef POOL_WINDOW_GEN_FRAME_DONE_EN
    , .frame_done(fd3)
`endif
  );

  pool_window_gen #(.IMG_W(6), .IMG_H(6), .STRIDE(1)) dut1 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_in(pix_in),
    .data_out0(o1[0]), .data_out1(o1[1]), .data_out2(o1[2]),
    .data_out3(o1[3]), .data_out4(o1[4]), .data_out5(o1[5]),
    .data_out6(o1[6]), .data_out7(o1[7]), .data_out8(o1[8]),
    .valid_out(v1)
`ifdef POOL_WINDOW_GEN_FRAME_DONE_EN
    , .frame_done(fd1)
`endif
  );

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: frame image plus the spec's position rules, using plain mod.
  logic [7:0] img [2][6][6];
  int   mr [2] = '{0, 0};
  int   mc [2] = '{0, 0};
  logic ev [2] = '{1'b0, 1'b0};
  logic efd [2] = '{1'b0, 1'b0};
  win_t ed [2] = '{72'h0, 72'h0};
  int   s_m;
  win_t mlog3[$];
  win_t mlog1[$];
  win_t log3[$];
  win_t log1[$];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      s_m = (k == 0) ? 3 : 1;
      if (rst) begin
        mr[k] = 0; mc[k] = 0;
        ev[k] = 1'b0; efd[k] = 1'b0; ed[k] = '0;
      end else begin
        ev[k] = 1'b0;
        efd[k] = 1'b0;
        if (pix_valid) begin
          img[k][mr[k]][mc[k]] = pix_in;
          if (mr[k] >= 2 && mc[k] >= 2 &&
              (mr[k] - 2) % s_m == 0 && (mc[k] - 2) % s_m == 0) begin
            ev[k] = 1'b1;
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                ed[k][i*3+j] = img[k][mr[k]-2+i][mc[k]-2+j];
            if (k == 0) mlog3.push_back(ed[k]);
            else        mlog1.push_back(ed[k]);
          end
          if (mr[k] == 5 && mc[k] == 5) efd[k] = 1'b1;
          if (mc[k] == 5) begin
            mc[k] = 0;
            mr[k] = (mr[k] == 5) ? 0 : mr[k] + 1;
          end else begin
            mc[k] = mc[k] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("valid_s3", 72'(v3), 72'(ev[0]));
      chk("data_s3", o3, ed[0]);
      chk("valid_s1", 72'(v1), 72'(ev[1]));
      chk("data_s1", o1, ed[1]);
      if (v3) log3.push_back(o3);
      if (v1) log1.push_back(o1);
`ifdef POOL_WINDOW_GEN_FRAME_DONE_EN
      chk("fdone_s3", 72'(fd3), 72'(efd[0]));
      chk("fdone_s1", 72'(fd1), 72'(efd[1]));
      if (fd3) nfd3++;
`endif
    end
  end

  function automatic win_t l3(input int i);
    return (log3.size() > i) ? log3[i] : '0;
  endfunction
  function automatic win_t l1(input int i);
    return (log1.size() > i) ? log1[i] : '0;
  endfunction
  function automatic win_t m3(input int i);
    return (mlog3.size() > i) ? mlog3[i] : '0;
  endfunction

  task automatic drive(input logic v, input logic [7:0] p, input logic r);
    pix_valid = v;
    pix_in    = p;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int base, input bit stall);
    for (int i = 0; i < 36; i++) begin
      drive(1'b1, 8'(base + i), 1'b0);
      if (stall && (i % 4 == 3))
        repeat (5) drive(1'b0, 8'h5A, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_logs();
    log3.delete(); log1.delete();
    mlog3.delete(); mlog1.delete();
  endtask

  localparam win_t A1 = {8'd0, 8'd1, 8'd2, 8'd6, 8'd7, 8'd8,
                         8'd12, 8'd13, 8'd14};
  localparam win_t A2 = {8'd3, 8'd4, 8'd5, 8'd9, 8'd10, 8'd11,
                         8'd15, 8'd16, 8'd17};
  localparam win_t B1 = {8'd100, 8'd101, 8'd102, 8'd106, 8'd107,
                         8'd108, 8'd112, 8'd113, 8'd114};

  win_t ref_a [4];
  win_t w;
  int n3, n1;

  initial begin
    n3 = ((6 - 3) / 3 + 1) * ((6 - 3) / 3 + 1);
    n1 = ((6 - 3) / 1 + 1) * ((6 - 3) / 1 + 1);
    rst = 1'b1;
    pix_valid = 1'b1;
    pix_in = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    run = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    chk("reset_data_s3", o3, 72'h0);
    chk("reset_valid_s3", 72'(v3), 72'h0);

    clear_logs();
`ifdef POOL_WINDOW_GEN_FRAME_DONE_EN
    nfd3 = 0;
`endif
    frame(0, 1'b0);
    frame(100, 1'b0);
    idle(3);
    chk("count_two_frames_s3", 72'(log3.size()), 72'(2 * n3));
    chk("count_two_frames_s1", 72'(log1.size()), 72'(2 * n1));
    chk("first_win_s3", l3(0), A1);
    chk("second_win_s3", l3(1), A2);
    chk("model_first_win", m3(0), A1);
    chk("model_second_win", m3(1), A2);
    chk("model_count_s1", 72'(mlog1.size()), 72'd32);
    chk("frame2_first_win_s1", l1(16), B1);
`ifdef POOL_WINDOW_GEN_FRAME_DONE_EN
    chk("frame_done_count", 72'(nfd3), 72'd2);
`endif
    for (int i = 0; i < 4; i++) ref_a[i] = l3(i);

    clear_logs();
    frame(0, 1'b1);
    idle(3);
    chk("count_stall_s3", 72'(log3.size()), 72'(n3));
    for (int i = 0; i < 4; i++) chk("stall_win_s3", l3(i), ref_a[i]);

    for (int i = 0; i < 21; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b1, 8'd99, 1'b1);
    clear_logs();
    frame(0, 1'b0);
    idle(3);
    chk("count_after_rst_s3", 72'(log3.size()), 72'(n3));
    chk("count_after_rst_s1", 72'(log1.size()), 72'(n1));
    for (int i = 0; i < 4; i++) chk("after_rst_win_s3", l3(i), ref_a[i]);

    clear_logs();
    frame(128, 1'b0);
    idle(3);
    w = l3(0);
    chk("signed_d0", 72'(w[0]), 72'h80);
    chk("signed_d8", 72'(w[8]), 72'h8E);
    chk("signed_count_s3", 72'(log3.size()), 72'(n3));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/pool_window_gen.md
POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning feature-map width in pixels (legal: 3..1024).
REQ-002 SHALL have parameter IMG_H, default 28, meaning feature-map height in pixels (legal: 3..1024).
REQ-003 SHALL have parameter STRIDE, default 3, meaning window step in both directions (legal: 1..3).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-006 SHALL have port pix_valid  input  1  meaning pix_in carries a pixel this cycle.
REQ-007 SHALL have port pix_in  input  8  meaning the signed int8 pixel, raster order, row 0 col 0 first.
REQ-008 SHALL have ports data_out0..data_out8  output  8 each  meaning the signed 3x3 window, row-major, data_out0 top-left, data_out8 bottom-right.
REQ-009 SHALL have port valid_out  output  1  meaning data_out0..8 hold a complete window this cycle.

Function
REQ-010 SHALL keep col counter (0..IMG_W-1) and row counter (0..IMG_H-1), advancing col on each accepted pixel, wrapping col to 0 and incrementing row at IMG_W-1.
REQ-011 SHALL wrap row to 0 after pixel (IMG_H-1, IMG_W-1); the next accepted pixel is (0,0) of a new frame.
REQ-012 SHALL store the two previous rows in two IMG_W-deep line buffers and keep a 3x3 register window shifting left by one column per accepted pixel.
REQ-013 SHALL treat pixel (r,c) as completing the window whose top-left is (r-2,c-2) when r>=2, c>=2, (r-2) mod STRIDE==0, (c-2) mod STRIDE==0.
REQ-014 SHALL realise the mod-STRIDE tests with phase counters, not dividers.
REQ-015 SHALL assert valid_out for exactly one cycle, the cycle after the completing pixel is accepted, with data_out0..8 = pixels (r-2..r, c-2..c), row-major.
REQ-016 SHALL never form a window spanning two rows' column wrap; window columns at c<2 SHALL never be emitted.
REQ-017 SHALL hold all state (counters, buffers, window) unchanged and drive valid_out=0 in any cycle with pix_valid=0; stalls of any length SHALL be transparent.
REQ-018 SHALL hold data_out0..8 at their last values while valid_out=0.
REQ-019 SHALL emit exactly ((IMG_W-3)/STRIDE+1)*((IMG_H-3)/STRIDE+1) windows per frame (integer division).
REQ-020 SHALL sustain one pixel per cycle with no bubbles, including across frame boundaries.
REQ-021 SHALL copy pixel bits unaltered; no arithmetic on data.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, clear col, row, phase counters, valid_out and data_out0..8 to 0.
REQ-023 SHALL NOT require reset of line-buffer contents; stale contents SHALL never reach data_out.
REQ-024 SHALL, on reset mid-frame, discard the partial frame; the first pixel accepted after rst falls is (0,0).
REQ-025 SHALL ignore pix_valid during any cycle rst=1.

Configuration
REQ-026 SHALL, with macro POOL_WINDOW_GEN_FRAME_DONE_EN defined, add output frame_done (1 bit), reset 0, pulsed high for one cycle the cycle after pixel (IMG_H-1, IMG_W-1) is accepted, coincident with the last valid_out when that pixel completes a window.
REQ-027 SHALL, without POOL_WINDOW_GEN_FRAME_DONE_EN, have no frame_done port and no associated logic; all other behaviour identical.

Verification
REQ-028 IMG_W=IMG_H=6, STRIDE=3, pixels 0..35 continuous -> 4 valid_out pulses; first after pixel 14 with data 0,1,2,6,7,8,12,13,14; second after pixel 17 with 3,4,5,9,10,11,15,16,17.
REQ-029 Same frame, pix_valid dropped for 5 cycles after every 4th pixel -> identical windows in identical order, valid_out never high during a stall.
REQ-030 IMG_W=IMG_H=6, STRIDE=1, two back-to-back frames -> 16 windows per frame, 32 total; first window of frame 2 contains only frame-2 pixels.
REQ-031 rst=1 for one cycle after pixel 20, then fresh frame 0..35 -> output identical to REQ-028; no window mixes pre-reset pixels.
REQ-032 Pixels -128..-93 (6x6, STRIDE=3) -> first window data_out0=-128, data_out8=-114; sign bits intact.
REQ-033 With POOL_WINDOW_GEN_FRAME_DONE_EN, REQ-028 stimulus -> single frame_done pulse coincident with 4th valid_out (after pixel 35).
